// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Patterns are active-high, bit 0 = segment a .. bit 6 = segment g.
package seg7_scan_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Smallest r with 2**r >= v; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One BCD nibble to an active-high 7-segment pattern.
// Dash wins over blank; nibbles 10-15 decode blank.
module seg7_digit_decode
   import seg7_scan_display_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] pat
);

   // Pattern lookup with dash/blank overrides
   always_comb begin
      pat = SEG_BLANK;
      if (dash) begin
         pat = SEG_DASH;
      end else if (!blank) begin
         case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Iterative binary-to-BCD converter feeding a double-buffered,
// time-multiplexed 7-segment display with blanking and overflow dash.
module seg7_scan_display
   import seg7_scan_display_pkg::*;
#(
   parameter int BITS       = 14,
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_LZ   = 1,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [BITS-1:0]       value,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = clog2(BITS + 1);
   localparam int SW = clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? clog2(DIGITS) : 1;

   state_e state_q, state_d;

   logic [BITS-1:0] sreg_q, sreg_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_acc_q, ovf_acc_d;
   logic [AW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   disp_q, disp_d;
   logic            disp_ovf_q, disp_ovf_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]   scan_idx_q, scan_idx_d;

   logic [AW-1:0]   acc_adj;
   logic [AW-1:0]   acc_sh;
   logic [BITS-1:0] sreg_sh;
   logic            ovf_sh;
   logic            last_bit;

   logic [3:0]      cur_nib;
   logic            cur_blank;
   logic [6:0]      cur_pat;
   logic [DIGITS-1:0] an_hot;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (load) state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy  = 1'b0;
      valid = 1'b0;
      unique case (state_q)
         ST_SHIFT: busy  = 1'b1;
         ST_DONE:  valid = 1'b1;
         default:  ;
      endcase
   end

   // Add-3 correction on every nibble, then one-bit shift of {acc, bin}
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      acc_sh   = {acc_adj[AW-2:0], sreg_q[BITS-1]};
      sreg_sh  = {sreg_q[BITS-2:0], 1'b0};
      ovf_sh   = ovf_acc_q | acc_adj[AW-1];
      last_bit = (cnt_q == CW'(BITS - 1));
   end

   // Conversion datapath; results land as DONE is entered so they
   // are already stable during the valid cycle
   always_comb begin
      sreg_d     = sreg_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_acc_d  = ovf_acc_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      disp_d     = disp_q;
      disp_ovf_d = disp_ovf_q;
      if (state_q == ST_IDLE && load) begin
         sreg_d    = value;
         acc_d     = '0;
         cnt_d     = '0;
         ovf_acc_d = 1'b0;
      end else if (state_q == ST_SHIFT) begin
         sreg_d    = sreg_sh;
         acc_d     = acc_sh;
         cnt_d     = cnt_q + CW'(1);
         ovf_acc_d = ovf_sh;
         if (last_bit) begin
            bcd_d      = acc_sh;
            ovf_d      = ovf_sh;
            disp_d     = acc_sh;
            disp_ovf_d = ovf_sh;
         end
      end
   end

   // Conversion and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_acc_q  <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
      end else begin
         sreg_q     <= sreg_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_acc_q  <= ovf_acc_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         disp_q     <= disp_d;
         disp_ovf_q <= disp_ovf_d;
      end
   end

   // Scan divider and digit index
   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         if (scan_idx_q == IW'(DIGITS - 1)) scan_idx_d = '0;
         else                               scan_idx_d = scan_idx_q + IW'(1);
      end
   end

   // Scan registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
      end
   end

   // Select the scanned nibble; blank it if it and all higher are zero
   always_comb begin
      cur_nib   = 4'd0;
      cur_blank = (BLANK_LZ != 0) && (scan_idx_q != '0);
      an_hot    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         an_hot[i] = (IW'(i) == scan_idx_q);
         if (IW'(i) == scan_idx_q) cur_nib = disp_q[4*i +: 4];
         if (i >= int'(scan_idx_q) && disp_q[4*i +: 4] != 4'd0)
            cur_blank = 1'b0;
      end
   end

   seg7_digit_decode u_dec (
      .nib   (cur_nib),
      .blank (cur_blank),
      .dash  (disp_ovf_q),
      .pat   (cur_pat)
   );

   assign bcd      = bcd_q;
   assign overflow = ovf_q;
   assign seg      = (ACTIVE_LOW != 0) ? ~cur_pat : cur_pat;
   assign an       = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;

endmodule
